// File: rtl/pkt_ram_pkg.sv
// Shared types and default sizing for the packet RAM read path.
`timescale 1ns/1ps
package pkt_ram_pkg;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int PKT_LEN_DEF = 32;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPT, PRESENT, CSUM, ACK, RELEASE
  } state_t;
endpackage

// File: rtl/pkt_ram_reader_if.sv
// Bus bundle between the packet RAM reader, the RAM and the downstream byte consumer.
`timescale 1ns/1ps
interface pkt_ram_reader_if
  import pkt_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              package_full;
  logic [DATA_W-1:0] ram_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              pkt_done;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt;

  modport master (
    input  package_full, ram_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, out_sop, out_eop,
           pkt_done, busy, pkt_cnt
  );
  modport slave (
    output package_full, ram_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, out_sop, out_eop,
           pkt_done, busy, pkt_cnt
  );
endinterface

// File: rtl/pkt_out_reg.sv
// Output holding register for the byte stream; contents change only on a load,
// so data/sop/eop stay frozen while the consumer stalls.
`timescale 1ns/1ps
module pkt_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop
);
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
    end else if (i_load) begin
      // load beats pop: the checksum byte replaces the last data byte in one edge
      o_data  <= i_data;
      o_valid <= 1'b1;
      o_sop   <= i_sop;
      o_eop   <= i_eop;
    end else if (i_pop) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pkt_ram_reader.sv
// Packet RAM read controller: walks addresses 0..PKT_LEN-1 once per package_full
// and streams the bytes out. Optional trailing checksum byte under PKT_RD_CHKSUM_EN.
`timescale 1ns/1ps
module pkt_ram_reader
  import pkt_ram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  pkt_ram_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PKT_LEN - 1);

  state_t            r_state, w_state_nxt;
  logic              r_rd_en, r_pkt_done, r_busy;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic              w_last, w_load, w_pop, w_sop_in, w_eop_in;
  logic [DATA_W-1:0] w_data_in, w_out_data;
  logic              w_out_valid, w_out_sop, w_out_eop;

`ifdef PKT_RD_CHKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_nxt;
  assign w_sum_nxt = r_sum + w_out_data;
`endif

  assign w_last = (r_rd_addr == LAST_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_data_in   = bus.ram_data;
    w_sop_in    = (r_rd_addr == '0);
    w_eop_in    = 1'b0;
    case (r_state)
      IDLE:    if (bus.package_full) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = CAPT;
      CAPT: begin
        w_load = 1'b1;
`ifdef PKT_RD_CHKSUM_EN
        w_eop_in = 1'b0;
`else
        w_eop_in = w_last;
`endif
        w_state_nxt = PRESENT;
      end
      PRESENT: if (bus.out_ready) begin
        w_pop = 1'b1;
        if (!w_last) begin
          w_state_nxt = ISSUE;
        end else begin
`ifdef PKT_RD_CHKSUM_EN
          // two's complement makes the whole PKT_LEN+1 byte stream sum to zero
          w_load      = 1'b1;
          w_data_in   = -w_sum_nxt;
          w_sop_in    = 1'b0;
          w_eop_in    = 1'b1;
          w_state_nxt = CSUM;
`else
          w_state_nxt = ACK;
`endif
        end
      end
`ifdef PKT_RD_CHKSUM_EN
      CSUM: if (bus.out_ready) begin
        w_pop       = 1'b1;
        w_state_nxt = ACK;
      end
`endif
      ACK:     w_state_nxt = RELEASE;
      // hold until the writer drops package_full so a stale packet is not re-read
      RELEASE: if (!bus.package_full) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_pkt_done <= 1'b0;
      r_busy     <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_en    <= (w_state_nxt == ISSUE);
      r_busy     <= (w_state_nxt != IDLE);
      r_pkt_done <= (w_state_nxt == ACK);
      if (w_state_nxt == ACK) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (r_state == IDLE && w_state_nxt == ISSUE)
        r_rd_addr <= '0;
      else if (r_state == PRESENT && w_state_nxt == ISSUE)
        r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

`ifdef PKT_RD_CHKSUM_EN
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      r_sum <= '0;
    else if (r_state == IDLE && w_state_nxt == ISSUE)
      r_sum <= '0;
    else if (r_state == PRESENT && w_pop)
      r_sum <= w_sum_nxt;
  end
`endif

  pkt_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_load  (w_load),
    .i_pop   (w_pop),
    .i_data  (w_data_in),
    .i_sop   (w_sop_in),
    .i_eop   (w_eop_in),
    .o_data  (w_out_data),
    .o_valid (w_out_valid),
    .o_sop   (w_out_sop),
    .o_eop   (w_out_eop)
  );

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_data  = w_out_data;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sop   = w_out_sop;
  assign bus.out_eop   = w_out_eop;
  assign bus.pkt_done  = r_pkt_done;
  assign bus.busy      = r_busy;
  assign bus.pkt_cnt   = r_pkt_cnt;
endmodule

// File: tb/tb_pkt_ram_reader.sv
// Scoreboard bench for pkt_ram_reader: expected beats queued per packet, popped on handshake.
`timescale 1ns/1ps
module tb_pkt_ram_reader;
  import pkt_ram_pkg::*;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int PL = PKT_LEN_DEF;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  pkt_ram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  pkt_ram_reader #(.ADDR_W(AW), .DATA_W(DW), .PKT_LEN(PL)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  logic [DW-1:0] mem [PL];
  beat_t exp_q[$];
  int    vectors = 0, miscompares = 0, exp_cnt = 0;
  logic  stall_p = 1'b0;
  beat_t stall_b = '0;

  always @(posedge clk_in) if (bus.rd_en) bus.ram_data <= mem[bus.rd_addr];

  // stream monitor: scoreboard pop on handshake, hold check under backpressure
  always @(negedge clk_in) begin
    beat_t got, e;
    got = {bus.out_data, bus.out_sop, bus.out_eop};
    if (rst && stall_p) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || got !== stall_b) begin
        miscompares++;
        $display("FAIL hold: got v=%b %h want v=1 %h", bus.out_valid, got, stall_b);
      end
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_beat: got %h want none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL beat: got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                   got.d, got.sop, got.eop, e.d, e.sop, e.eop);
        end
      end
    end
    stall_p <= rst && bus.out_valid && !bus.out_ready;
    stall_b <= got;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic load_mem(input int mode);
    for (int i = 0; i < PL; i++)
      case (mode)
        0: mem[i] = DW'(32'h56 + i);
        1: mem[i] = DW'(i * 7 + 3);
        2: mem[i] = DW'(32'hA0 ^ i);
        default: mem[i] = DW'(1);
      endcase
  endtask

  task automatic push_pkt();
    logic [DW-1:0] sum, ck;
    logic eop;
    sum = '0;
    for (int i = 0; i < PL; i++) begin
`ifdef PKT_RD_CHKSUM_EN
      eop = 1'b0;
`else
      eop = (i == PL - 1);
`endif
      exp_q.push_back({mem[i], (i == 0), eop});
      sum = sum + mem[i];
    end
`ifdef PKT_RD_CHKSUM_EN
    ck = -sum;
    exp_q.push_back({ck, 1'b0, 1'b1});
`else
    ck = sum;
`endif
  endtask

  task automatic wait_done(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 2000) begin
      @(negedge clk_in);
      n++;
      if (bus.pkt_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.package_full = 1'b0;
    bus.out_ready    = 1'b0;
    #200;
    vectors++;
    if ({bus.rd_en, bus.rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_rd: got en=%b addr=%h want 0", bus.rd_en, bus.rd_addr);
    end
    vectors++;
    if ({bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop} !== '0) begin
      miscompares++;
      $display("FAIL reset_out: got d=%h v=%b s=%b e=%b want 0",
               bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop);
    end
    vectors++;
    if ({bus.pkt_done, bus.busy, bus.pkt_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got done=%b busy=%b cnt=%0d want 0",
               bus.pkt_done, bus.busy, bus.pkt_cnt);
    end
    #300;
    @(posedge clk_in); #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b en=%b want 0 0", bus.busy, bus.rd_en);
    end
  endtask

  task automatic test_full_drain();
    bit ok;
    int n;
    load_mem(0);
    push_pkt();
    @(posedge clk_in); #1;
    bus.out_ready    = 1'b1;
    bus.package_full = 1'b1;
    @(negedge clk_in);
    vectors++;
    if (bus.rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL early_rd_en: got %b want 0", bus.rd_en);
    end
    @(negedge clk_in);
    vectors++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin
      miscompares++;
      $display("FAIL first_issue: got en=%b addr=%0d want 1 0", bus.rd_en, bus.rd_addr);
    end
    @(negedge clk_in);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capt_valid: got %b want 0", bus.out_valid);
    end
    @(negedge clk_in);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1) begin
      miscompares++;
      $display("FAIL first_present: got v=%b sop=%b want 1 1", bus.out_valid, bus.out_sop);
    end
    wait_done(ok, n);
    exp_cnt++;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain_done: got timeout want pkt_done");
    end
`ifndef PKT_RD_CHKSUM_EN
    vectors++;
    if (2 + n != 3 * PL) begin
      miscompares++;
      $display("FAIL drain_cycles: got %0d want %0d", 2 + n, 3 * PL);
    end
`endif
    vectors++;
    if (bus.pkt_cnt !== CNT_W'(exp_cnt) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_cnt: got cnt=%0d left=%0d want cnt=%0d left=0",
               bus.pkt_cnt, exp_q.size(), exp_cnt);
    end
    @(negedge clk_in);
    vectors++;
    if (bus.pkt_done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got %b want 0", bus.pkt_done);
    end
  endtask

  task automatic test_release_gate();
    int bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (bus.rd_en !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL release_hold: got %0d bad cycles want 0", bad);
    end
    @(posedge clk_in); #1 bus.package_full = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL release_exit: got busy=%b en=%b want 0 0", bus.busy, bus.rd_en);
    end
  endtask

  task automatic test_backpressure();
    bit ok, found;
    int n, bad;
    load_mem(1);
    push_pkt();
    @(posedge clk_in); #1 bus.package_full = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge clk_in); #1;
      n++;
      if (bus.rd_en && bus.rd_addr == AW'(5)) found = 1'b1;
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL bp_find: got timeout want issue of byte 5");
    end
    @(negedge clk_in);
    @(negedge clk_in);
    bad = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (bus.out_valid !== 1'b1 || bus.out_data !== mem[5] || bus.rd_en !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_stall: got %0d bad cycles want 0", bad);
    end
    @(posedge clk_in); #1 bus.out_ready = 1'b1;
    wait_done(ok, n);
    exp_cnt++;
    vectors++;
    if (!ok || bus.pkt_cnt !== CNT_W'(exp_cnt) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_done: got ok=%b cnt=%0d left=%0d want 1 %0d 0",
               ok, bus.pkt_cnt, exp_q.size(), exp_cnt);
    end
    @(posedge clk_in); #1 bus.package_full = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic test_mid_reset();
    bit ok, found;
    int n;
    load_mem(2);
    push_pkt();
    @(posedge clk_in); #1 bus.package_full = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge clk_in); #1;
      n++;
      if (bus.rd_en && bus.rd_addr == AW'(12)) found = 1'b1;
    end
    #1 rst = 1'b0;
    #1;
    exp_cnt = 0;
    vectors++;
    if (!found || bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.pkt_done !== 1'b0 || bus.pkt_cnt !== CNT_W'(exp_cnt)) begin
      miscompares++;
      $display("FAIL abort: got found=%b v=%b en=%b busy=%b done=%b cnt=%0d want 1 0 0 0 0 %0d",
               found, bus.out_valid, bus.rd_en, bus.busy, bus.pkt_done, bus.pkt_cnt, exp_cnt);
    end
    exp_q.delete();
    bus.package_full = 1'b0;
    @(posedge clk_in); #1 rst = 1'b1;
    push_pkt();
    @(posedge clk_in); #1 bus.package_full = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk_in);
      n++;
      if (bus.rd_en) found = 1'b1;
    end
    vectors++;
    if (!found || bus.rd_addr !== '0) begin
      miscompares++;
      $display("FAIL restart_addr: got found=%b addr=%0d want 1 0", found, bus.rd_addr);
    end
    wait_done(ok, n);
    exp_cnt++;
    vectors++;
    if (!ok || bus.pkt_cnt !== CNT_W'(exp_cnt) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_done: got ok=%b cnt=%0d left=%0d want 1 %0d 0",
               ok, bus.pkt_cnt, exp_q.size(), exp_cnt);
    end
    @(posedge clk_in); #1 bus.package_full = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic test_all_ones();
    bit ok;
    int n;
    load_mem(3);
    push_pkt();
    @(posedge clk_in); #1 bus.package_full = 1'b1;
    wait_done(ok, n);
    exp_cnt++;
    vectors++;
    if (!ok || bus.pkt_cnt !== CNT_W'(exp_cnt) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ones_done: got ok=%b cnt=%0d left=%0d want 1 %0d 0",
               ok, bus.pkt_cnt, exp_q.size(), exp_cnt);
    end
    @(posedge clk_in); #1 bus.package_full = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_release_gate();
    test_backpressure();
    test_mid_reset();
    test_all_ones();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
